pe_seq_ctrl: RTL and testbench
==============================

Name: pe_seq_ctrl

Overview:
- Sequencing controller for one PE.
- Takes one job descriptor, then drives the PE's start pulses in order: config, weight load, feature load, MAC wait, psum-in load, psum-out.
- Routes a single shared valid/ready source stream (global buffer read port) onto the PE's weight, feature or psum input, honouring the PE FIFO-full backpressure.
- Sits between the global-buffer read engine and pe; reports job completion to the array-level scheduler.

Parameters:
DATA_WIDTH, 16, width of source stream and PE data inputs
CNT_WIDTH, 8, width of per-phase word counts
MAC_TIMEOUT, 1024, max cycles waiting for mac_finish or psum_out_valid before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
job_start  in  1  one-cycle pulse; accepted only in IDLE
n_weight  in  CNT_WIDTH  weight words for this job; 0 = weights resident, skip phase
n_fmap  in  CNT_WIDTH  feature words; 0 = skip phase
n_psum  in  CNT_WIDTH  psum-in words; 0 = skip phase
full_col  in  1  value driven on load_full_cloumn for this job
abort  in  1  synchronous abort, any state
src_data  in  DATA_WIDTH  source stream data
src_valid  in  1  source stream valid
src_ready  out  1  source stream ready
start_config  out  1  PE config pulse
start_weight_load  out  1  PE pulse
start_feature_load  out  1  PE pulse
start_psum_in_load  out  1  PE pulse
start_psum_out  out  1  PE pulse
load_full_cloumn  out  1  latched full_col
weight_in  out  DATA_WIDTH  to PE
weight_in_en  out  1  to PE
feature_in  out  DATA_WIDTH  to PE
feature_in_en  out  1  to PE
psum_in  out  DATA_WIDTH  to PE
psum_in_en  out  1  to PE
fifo_full_fmap  in  1  from PE
fifo_full_filter  in  1  from PE
mac_finish  in  1  from PE
psum_out_valid  in  1  from PE
busy  out  1  high in any state but IDLE
job_done  out  1  one-cycle pulse on completion
timeout_err  out  1  sticky until next accepted job_start

Behaviour:
- Reset: state IDLE; all outputs 0; counters and latched descriptor cleared.
- Reset mid-job abandons the job; no done pulse.
- job_start in IDLE latches n_weight, n_fmap, n_psum and full_col, clears timeout_err, and moves to CFG. job_start outside IDLE is ignored.
- States and transitions:
  - IDLE.
  - CFG: start_config=1 for one cycle, then go to W_START.
  - W_START: skipped if n_weight==0. Pulse start_weight_load, go to W_LOAD.
  - W_LOAD: stream n_weight words.
  - F_START / F_LOAD: same pattern for fmap.
  - MAC_WAIT: wait for mac_finish.
  - P_START / P_LOAD: same pattern for psum-in; skipped if n_psum==0.
  - OUT_START: pulse start_psum_out.
  - OUT_WAIT: wait for psum_out_valid.
  - DONE: job_done=1 for one cycle, then IDLE.
- A skipped phase costs zero cycles; the next START state is entered directly.
- MAC_WAIT is entered only after F_LOAD completes. It is bypassed if n_fmap==0; then job_done still fires but mac_finish is not awaited.
- Load handshake (combinational):
  - W_LOAD: src_ready = !fifo_full_filter.
  - F_LOAD: src_ready = !fifo_full_fmap.
  - P_LOAD: src_ready = 1.
  - All other states: src_ready = 0.
  - A transfer occurs when src_valid & src_ready. The matching *_in_en equals the transfer condition that cycle; *_in = src_data. Unselected *_in_en = 0.
  - Word counter increments per transfer; it resets to 0 on entry to each START state.
  - The phase ends on the cycle the count reaches the target; the next state is taken at the following edge.
- load_full_cloumn holds the latched full_col from CFG through DONE; it is 0 in IDLE.
- Timeout: MAC_WAIT and OUT_WAIT each count cycles. At MAC_TIMEOUT: set timeout_err, go to DONE (job_done still pulses).
- abort: go to IDLE at the next edge; no job_done pulse; src_ready is 0 that cycle. abort has priority over job_start and over phase completion in the same cycle.
- mac_finish arriving before MAC_WAIT is not remembered; the PE guarantees it comes after the final feature word.
- Counts are unsigned. CNT_WIDTH bounds each phase at 255 words.

Decomposition:
- Shared package pe_ctrl_pkg: state encoding constants (4-bit) and the MAC_TIMEOUT default.
- One natural sub-module, pe_stream_mux: load-phase select, src_ready/*_in_en routing and word counter.

Test Plan:
- Full job, n_weight=36, n_fmap=12, n_psum=3, src_valid always high, no backpressure -> each start pulse exactly one cycle in order; 36/12/3 en pulses; job_done after psum_out_valid.
- Backpressure: hold fifo_full_filter high for 5 cycles mid-weight phase -> src_ready and weight_in_en low for those 5 cycles; total still 36 words; no data loss or duplication.
- n_weight=0, n_psum=0 -> no start_weight_load or start_psum_in_load; CFG goes straight to F_START; job_done still fires.
- Withhold mac_finish with MAC_TIMEOUT=16 -> timeout_err set 16 cycles after MAC_WAIT entry; job_done pulses; next job_start clears timeout_err.
- abort after 4 fmap words -> IDLE next cycle; busy=0; no job_done. A new job then runs cleanly.
- Assert rst mid-F_LOAD -> all outputs 0 immediately (async); state IDLE.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared types for the PE sequencing controller.
// State encoding, load-phase select and the MAC wait timeout default.
package pe_ctrl_pkg;

    localparam int MAC_TIMEOUT_DEF = 1024;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CFG       = 4'd1,
        ST_W_START   = 4'd2,
        ST_W_LOAD    = 4'd3,
        ST_F_START   = 4'd4,
        ST_F_LOAD    = 4'd5,
        ST_MAC_WAIT  = 4'd6,
        ST_P_START   = 4'd7,
        ST_P_LOAD    = 4'd8,
        ST_OUT_START = 4'd9,
        ST_OUT_WAIT  = 4'd10,
        ST_DONE      = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_W    = 2'd1,
        SEL_F    = 2'd2,
        SEL_P    = 2'd3
    } sel_t;

endpackage

// File: rtl/pe_stream_mux.sv
// pe_stream_mux: routes the shared source stream onto one PE input
// and counts the words of the current load phase.
module pe_stream_mux
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  sel_t                  sel,
    input  logic                  clear,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  target,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    input  logic                  fifo_full_filter,
    input  logic                  fifo_full_fmap,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] weight_in,
    output logic                  weight_in_en,
    output logic [DATA_WIDTH-1:0] feature_in,
    output logic                  feature_in_en,
    output logic [DATA_WIDTH-1:0] psum_in,
    output logic                  psum_in_en,
    output logic                  last
);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 xfer;

    // Handshake routing; the phase completes on the transfer of its final word.
    always_comb begin
        src_ready = 1'b0;
        unique case (sel)
            SEL_W:   src_ready = !fifo_full_filter;
            SEL_F:   src_ready = !fifo_full_fmap;
            SEL_P:   src_ready = 1'b1;
            default: src_ready = 1'b0;
        endcase
        if (abort) src_ready = 1'b0;
        xfer          = src_valid && src_ready;
        weight_in_en  = xfer && (sel == SEL_W);
        feature_in_en = xfer && (sel == SEL_F);
        psum_in_en    = xfer && (sel == SEL_P);
        weight_in     = (sel == SEL_W) ? src_data : '0;
        feature_in    = (sel == SEL_F) ? src_data : '0;
        psum_in       = (sel == SEL_P) ? src_data : '0;
        last          = xfer && (cnt == target - CNT_WIDTH'(1));
    end

    // Word counter, restarted by each START state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (clear) cnt <= '0;
        else if (xfer)  cnt <= cnt + CNT_WIDTH'(1);
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: per-PE job sequencer driving config, load, MAC and
// psum-out phases from one job descriptor.
module pe_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_WIDTH   = 8,
    parameter int MAC_TIMEOUT = MAC_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_start,
    input  logic [CNT_WIDTH-1:0]  n_weight,
    input  logic [CNT_WIDTH-1:0]  n_fmap,
    input  logic [CNT_WIDTH-1:0]  n_psum,
    input  logic                  full_col,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  start_config,
    output logic                  start_weight_load,
    output logic                  start_feature_load,
    output logic                  start_psum_in_load,
    output logic                  start_psum_out,
    output logic                  load_full_cloumn,
    output logic [DATA_WIDTH-1:0] weight_in,
    output logic                  weight_in_en,
    output logic [DATA_WIDTH-1:0] feature_in,
    output logic                  feature_in_en,
    output logic [DATA_WIDTH-1:0] psum_in,
    output logic                  psum_in_en,
    input  logic                  fifo_full_fmap,
    input  logic                  fifo_full_filter,
    input  logic                  mac_finish,
    input  logic                  psum_out_valid,
    output logic                  busy,
    output logic                  job_done,
    output logic                  timeout_err
);

    localparam int TW = $clog2(MAC_TIMEOUT + 1);

    state_t               state, nxt, after_w, after_mac;
    sel_t                 sel;
    logic [CNT_WIDTH-1:0] nw_q, nf_q, np_q, target;
    logic                 fc_q, accept, tmo_hit, tmo_at, in_wait;
    logic                 last, clear;
    logic [TW-1:0]        tcnt;

    assign after_mac = (np_q != '0) ? ST_P_START : ST_OUT_START;
    assign after_w   = (nf_q != '0) ? ST_F_START : after_mac;
    assign accept    = (state == ST_IDLE) && job_start && !abort;
    assign in_wait   = (state == ST_MAC_WAIT) || (state == ST_OUT_WAIT);
    assign tmo_at    = (tcnt == TW'(MAC_TIMEOUT - 1));

    assign busy             = (state != ST_IDLE);
    assign job_done         = (state == ST_DONE);
    assign load_full_cloumn = busy && fc_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    // Descriptor latch, taken only when a job is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nw_q <= '0;
            nf_q <= '0;
            np_q <= '0;
            fc_q <= 1'b0;
        end else if (accept) begin
            nw_q <= n_weight;
            nf_q <= n_fmap;
            np_q <= n_psum;
            fc_q <= full_col;
        end
    end

    // Cycle counter for the two wait states; idle elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tcnt <= '0;
        else if (!in_wait) tcnt <= '0;
        else              tcnt <= tcnt + TW'(1);
    end

    // Sticky timeout flag, cleared by the next accepted job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         timeout_err <= 1'b0;
        else if (accept)  timeout_err <= 1'b0;
        else if (tmo_hit) timeout_err <= 1'b1;
    end

    // Load-phase select; kept apart from next-state to avoid a loop through last.
    always_comb begin
        sel    = SEL_NONE;
        target = '0;
        clear  = 1'b0;
        unique case (state)
            ST_W_START, ST_F_START, ST_P_START: clear = 1'b1;
            ST_W_LOAD: begin sel = SEL_W; target = nw_q; end
            ST_F_LOAD: begin sel = SEL_F; target = nf_q; end
            ST_P_LOAD: begin sel = SEL_P; target = np_q; end
            default: ;
        endcase
    end

    // Next-state and start pulses; abort overrides everything.
    always_comb begin
        nxt                = state;
        tmo_hit            = 1'b0;
        start_config       = 1'b0;
        start_weight_load  = 1'b0;
        start_feature_load = 1'b0;
        start_psum_in_load = 1'b0;
        start_psum_out     = 1'b0;
        unique case (state)
            ST_IDLE:   if (job_start) nxt = ST_CFG;
            ST_CFG: begin
                start_config = 1'b1;
                nxt = (nw_q != '0) ? ST_W_START : after_w;
            end
            ST_W_START: begin
                start_weight_load = 1'b1;
                nxt = ST_W_LOAD;
            end
            ST_W_LOAD: if (last) nxt = after_w;
            ST_F_START: begin
                start_feature_load = 1'b1;
                nxt = ST_F_LOAD;
            end
            ST_F_LOAD: if (last) nxt = ST_MAC_WAIT;
            ST_MAC_WAIT: begin
                if (mac_finish) nxt = after_mac;
                else if (tmo_at) begin
                    nxt = ST_DONE;
                    tmo_hit = 1'b1;
                end
            end
            ST_P_START: begin
                start_psum_in_load = 1'b1;
                nxt = ST_P_LOAD;
            end
            ST_P_LOAD: if (last) nxt = ST_OUT_START;
            ST_OUT_START: begin
                start_psum_out = 1'b1;
                nxt = ST_OUT_WAIT;
            end
            ST_OUT_WAIT: begin
                if (psum_out_valid) nxt = ST_DONE;
                else if (tmo_at) begin
                    nxt = ST_DONE;
                    tmo_hit = 1'b1;
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
        if (abort) begin
            nxt = ST_IDLE;
            tmo_hit = 1'b0;
        end
    end

    pe_stream_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_mux (
        .clk              (clk),
        .rst              (rst),
        .sel              (sel),
        .clear            (clear),
        .abort            (abort),
        .target           (target),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .fifo_full_filter (fifo_full_filter),
        .fifo_full_fmap   (fifo_full_fmap),
        .src_ready        (src_ready),
        .weight_in        (weight_in),
        .weight_in_en     (weight_in_en),
        .feature_in       (feature_in),
        .feature_in_en    (feature_in_en),
        .psum_in          (psum_in),
        .psum_in_en       (psum_in_en),
        .last             (last)
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed jobs against a job-level event/word model
// of the PE sequencer.
module tb_pe_seq_ctrl;

    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_start;
    logic [CW-1:0] n_weight, n_fmap, n_psum;
    logic          full_col, abort;
    logic [DW-1:0] src_data;
    logic          src_valid, src_ready;
    logic          start_config, start_weight_load, start_feature_load;
    logic          start_psum_in_load, start_psum_out, load_full_cloumn;
    logic [DW-1:0] weight_in, feature_in, psum_in;
    logic          weight_in_en, feature_in_en, psum_in_en;
    logic          fifo_full_fmap, fifo_full_filter;
    logic          mac_finish, psum_out_valid;
    logic          busy, job_done, timeout_err;

    pe_seq_ctrl #(
        .DATA_WIDTH  (DW),
        .CNT_WIDTH   (CW),
        .MAC_TIMEOUT (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .job_start          (job_start),
        .n_weight           (n_weight),
        .n_fmap             (n_fmap),
        .n_psum             (n_psum),
        .full_col           (full_col),
        .abort              (abort),
        .src_data           (src_data),
        .src_valid          (src_valid),
        .src_ready          (src_ready),
        .start_config       (start_config),
        .start_weight_load  (start_weight_load),
        .start_feature_load (start_feature_load),
        .start_psum_in_load (start_psum_in_load),
        .start_psum_out     (start_psum_out),
        .load_full_cloumn   (load_full_cloumn),
        .weight_in          (weight_in),
        .weight_in_en       (weight_in_en),
        .feature_in         (feature_in),
        .feature_in_en      (feature_in_en),
        .psum_in            (psum_in),
        .psum_in_en         (psum_in_en),
        .fifo_full_fmap     (fifo_full_fmap),
        .fifo_full_filter   (fifo_full_filter),
        .mac_finish         (mac_finish),
        .psum_out_valid     (psum_out_valid),
        .busy               (busy),
        .job_done           (job_done),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input int got, input int want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Job-level model state.
    typedef enum int {EV_CFG, EV_W, EV_F, EV_P, EV_OUT, EV_DONE} ev_t;
    ev_t           evq[$];
    ev_t           phase = EV_DONE;
    bit            m_busy = 0, m_err = 0, job_fc = 0, job_tmo = 0;
    bit            hold_mac = 0, f_last = 0;
    int            job_nw, job_nf, job_np;
    int            cw = 0, cf = 0, cp = 0;
    int            ps[6];
    logic [DW-1:0] last_word = 16'h00FF;

    task automatic take_word(input string name, input logic [DW-1:0] d);
        check(name, int'(d), int'(last_word + 16'd1));
        last_word = d;
    endtask

    // Per-cycle comparison against the model, then model update.
    always @(negedge clk) begin : cmp
        logic [5:0] pv;
        int         npulse, nen;
        ev_t        got;
        f_last = 0;
        if (rst) begin
            evq.delete();
            m_busy = 0;
            m_err  = 0;
        end else begin
            pv = {job_done, start_psum_out, start_psum_in_load,
                  start_feature_load, start_weight_load, start_config};
            npulse = $countones(pv);
            check("one_pulse", int'(npulse <= 1), 1);
            got = EV_CFG;
            for (int i = 0; i < 6; i++) if (pv[i]) got = ev_t'(i);
            if (npulse == 1) begin
                if (evq.size() == 0) begin
                    check("unexpected_pulse", int'(got), -1);
                end else begin
                    check("pulse_order", int'(got), int'(evq[0]));
                    void'(evq.pop_front());
                    ps[got]++;
                    phase = got;
                    if (got == EV_DONE) begin
                        check("w_words", cw, job_nw);
                        check("f_words", cf, job_nf);
                        check("p_words", cp, job_tmo ? 0 : job_np);
                        if (job_tmo) m_err = 1;
                    end
                end
            end
            nen = int'(weight_in_en) + int'(feature_in_en) + int'(psum_in_en);
            check("one_en", int'(nen <= 1), 1);
            check("xfer_routed", nen, int'(src_valid && src_ready));
            if (weight_in_en) begin
                check("w_phase", int'(phase), int'(EV_W));
                check("w_backpressure", int'(fifo_full_filter), 0);
                take_word("w_data", weight_in);
                cw++;
            end
            if (feature_in_en) begin
                check("f_phase", int'(phase), int'(EV_F));
                check("f_backpressure", int'(fifo_full_fmap), 0);
                take_word("f_data", feature_in);
                cf++;
                if (cf == job_nf) f_last = 1;
            end
            if (psum_in_en) begin
                check("p_phase", int'(phase), int'(EV_P));
                take_word("p_data", psum_in);
                cp++;
            end
            if (!m_busy) check("idle_ready", int'(src_ready), 0);
            check("busy", int'(busy), int'(m_busy));
            check("full_col", int'(load_full_cloumn), m_busy ? int'(job_fc) : 0);
            check("timeout_err", int'(timeout_err), int'(m_err));
            if (abort && m_busy) begin
                m_busy = 0;
                evq.delete();
            end else if (job_done) begin
                m_busy = 0;
            end else if (job_start && !m_busy && !abort) begin
                m_busy  = 1;
                m_err   = 0;
                job_nw  = int'(n_weight);
                job_nf  = int'(n_fmap);
                job_np  = int'(n_psum);
                job_fc  = full_col;
                job_tmo = hold_mac;
                cw = 0; cf = 0; cp = 0;
                for (int i = 0; i < 6; i++) ps[i] = 0;
                phase = EV_CFG;
                evq.push_back(EV_CFG);
                if (job_nw != 0) evq.push_back(EV_W);
                if (job_nf != 0) evq.push_back(EV_F);
                if (!job_tmo) begin
                    if (job_np != 0) evq.push_back(EV_P);
                    evq.push_back(EV_OUT);
                end
                evq.push_back(EV_DONE);
            end
        end
    end

    // Source stream: advance data on each accepted word.
    initial begin : src_drv
        bit hs;
        src_data = 16'h0100;
        forever begin
            @(negedge clk);
            hs = src_valid && src_ready && !rst;
            @(posedge clk);
            #1;
            if (hs) src_data = src_data + 16'd1;
        end
    end

    // PE model: mac_finish some cycles after the last feature word.
    initial begin : mac_resp
        mac_finish = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (f_last && !hold_mac) begin
                repeat (3) @(posedge clk);
                #1 mac_finish = 1'b1;
                @(posedge clk);
                #1 mac_finish = 1'b0;
            end
        end
    end

    // PE model: psum_out_valid shortly after start_psum_out.
    initial begin : out_resp
        psum_out_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (start_psum_out && !rst) begin
                repeat (2) @(posedge clk);
                #1 psum_out_valid = 1'b1;
                @(posedge clk);
                #1 psum_out_valid = 1'b0;
            end
        end
    end

    task automatic start_job(input int nw, input int nf, input int np,
                             input bit fc, input bit tmo);
        @(posedge clk);
        #1;
        n_weight  = CW'(nw);
        n_fmap    = CW'(nf);
        n_psum    = CW'(np);
        full_col  = fc;
        hold_mac  = tmo;
        job_start = 1'b1;
        @(posedge clk);
        #1 job_start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (k < lim) begin
            @(negedge clk);
            #1;
            if (job_done) break;
            k++;
        end
        check("done_in_time", int'(k < lim), 1);
        check("queue_drained", evq.size(), 0);
    endtask

    task automatic wait_cnt(input int which, input int n, input int lim);
        int k = 0;
        int v;
        while (k < lim) begin
            @(negedge clk);
            #1;
            v = (which == 0) ? cw : cf;
            if (v >= n) break;
            k++;
        end
        check("cnt_reached", int'(k < lim), 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, int'({src_ready, start_config, start_weight_load,
              start_feature_load, start_psum_in_load, start_psum_out,
              load_full_cloumn, weight_in_en, feature_in_en, psum_in_en,
              busy, job_done, timeout_err}), 0);
        check({name, "_data"}, int'(weight_in | feature_in | psum_in), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        rst = 1'b1;
        job_start = 1'b0;
        n_weight = '0; n_fmap = '0; n_psum = '0;
        full_col = 1'b0; abort = 1'b0;
        src_valid = 1'b1;
        fifo_full_fmap = 1'b0; fifo_full_filter = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full job, no backpressure.
        start_job(36, 12, 3, 1'b1, 1'b0);
        wait_done(400);
        check("a_w", cw, 36);
        check("a_f", cf, 12);
        check("a_p", cp, 3);
        check("a_pulses", ps[EV_CFG] + ps[EV_W] + ps[EV_F] + ps[EV_P] + ps[EV_OUT], 5);

        // Filter FIFO full for 5 cycles mid-weight phase.
        start_job(36, 12, 3, 1'b0, 1'b0);
        wait_cnt(0, 10, 100);
        @(posedge clk);
        #1 fifo_full_filter = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready", int'(src_ready), 0);
            check("bp_en", int'(weight_in_en), 0);
        end
        check("bp_held", cw, 10);
        @(posedge clk);
        #1 fifo_full_filter = 1'b0;
        wait_done(400);
        check("b_w", cw, 36);

        // Weights resident, no psum-in.
        start_job(0, 5, 0, 1'b1, 1'b0);
        wait_done(200);
        check("c_no_w", ps[EV_W], 0);
        check("c_no_p", ps[EV_P], 0);
        check("c_f", cf, 5);

        // mac_finish withheld: timeout 16 cycles after MAC_WAIT entry.
        start_job(2, 3, 2, 1'b1, 1'b1);
        wait_cnt(1, 3, 100);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            #1;
            k++;
            if (timeout_err) break;
        end
        check("tmo_cycles", k, TMO + 1);
        check("tmo_done", int'(job_done), 1);
        repeat (3) @(negedge clk);
        check("tmo_sticky", int'(timeout_err), 1);

        // Next job clears the flag; no fmap means no MAC wait.
        start_job(3, 0, 2, 1'b0, 1'b0);
        @(negedge clk);
        check("tmo_cleared", int'(timeout_err), 0);
        wait_done(200);
        check("e_no_f", ps[EV_F], 0);
        check("e_p", cp, 2);

        // Abort after 4 feature words.
        start_job(2, 12, 2, 1'b1, 1'b0);
        wait_cnt(1, 4, 100);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_ready", int'(src_ready), 0);
        check("abort_en", int'(feature_in_en), 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle", int'(busy), 0);
        check("abort_f", cf, 4);
        repeat (4) @(negedge clk);

        // Clean job with a job_start pulse that must be ignored.
        start_job(4, 4, 4, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 n_weight = 8'd9;
        job_start = 1'b1;
        @(posedge clk);
        #1 job_start = 1'b0;
        wait_done(200);
        check("g_w", cw, 4);
        check("g_cfg_once", ps[EV_CFG], 1);

        // Asynchronous reset mid-feature-load.
        start_job(2, 12, 1, 1'b1, 1'b0);
        wait_cnt(1, 5, 100);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_idle", int'(busy), 0);

        // Small job after reset.
        start_job(1, 1, 1, 1'b1, 1'b0);
        wait_done(200);
        check("i_done", ps[EV_DONE], 1);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
